// File: rtl/pattern_pwm_pkg.sv
// Shared types for the pattern_pwm sequencer: FSM states, duty width and table entry layout.
// No logic here.
package pattern_pwm_pkg;

   localparam int DUTY_W    = 8;
   localparam int PAT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE
   } seq_state_t;

   typedef struct packed {
      logic [PAT_W_DEF-1:0] pat;
      logic [DUTY_W-1:0]    duty;
   } tbl_entry_t;

endpackage

// File: rtl/pattern_pwm_table.sv
// Pattern/duty register file: synchronous gated write, combinational read.
// Write lands on the clock edge; read is available in the same cycle.
module pattern_pwm_table
   import pattern_pwm_pkg::*;
#(
   parameter int  _PAT_WIDTH = 16,
   parameter int  _DEPTH     = 8,
   localparam int _ADDR_W    = $clog2(_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [_ADDR_W-1:0]    wr_addr,
   input  logic [_PAT_WIDTH-1:0] wr_pat,
   input  logic [DUTY_W-1:0]     wr_duty,
   input  logic [_ADDR_W-1:0]    rd_addr,
   output logic [_PAT_WIDTH-1:0] rd_pat,
   output logic [DUTY_W-1:0]     rd_duty
);

   logic [_PAT_WIDTH-1:0] pat_mem  [_DEPTH];
   logic [DUTY_W-1:0]     duty_mem [_DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < _DEPTH; i++) begin
            pat_mem[i]  <= '0;
            duty_mem[i] <= '0;
         end
      end else if (we) begin
         pat_mem[wr_addr]  <= wr_pat;
         duty_mem[wr_addr] <= wr_duty;
      end
   end

   assign rd_pat  = pat_mem[rd_addr];
   assign rd_duty = duty_mem[rd_addr];

endmodule

// File: rtl/pattern_pwm_seq.sv
// Plays a (PAT, duty) table into pattern_pwm for a set number of passes; one pwm_en per entry.
// pwm_en one edge after an accepted start or honoured valid; held off while pwm_busy is high.
module pattern_pwm_seq
   import pattern_pwm_pkg::*;
#(
   parameter int  _PAT_WIDTH = 16,
   parameter int  _DEPTH     = 8,
   localparam int _ADDR_W    = $clog2(_DEPTH),
   parameter int  _REP_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_we,
   input  logic [_ADDR_W-1:0]    cfg_addr,
   input  logic [_PAT_WIDTH-1:0] cfg_pat,
   input  logic [DUTY_W-1:0]     cfg_duty,
   input  logic [_ADDR_W:0]      seq_len,
   input  logic [_REP_W-1:0]     rep_num,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  pwm_busy,
   input  logic                  pwm_valid,
   output logic                  pwm_en,
   output logic [DUTY_W-1:0]     duty_num,
   output logic [_PAT_WIDTH-1:0] PAT,
   output logic                  seq_busy,
   output logic [_ADDR_W-1:0]    cur_idx,
   output logic                  done
);

   seq_state_t            state;
   logic [_ADDR_W-1:0]    idx;
   logic [_REP_W-1:0]     pass;
   logic [_ADDR_W:0]      len_q;
   logic [_REP_W-1:0]     rep_q;
   logic                  stop_flag;
   logic [_PAT_WIDTH-1:0] rd_pat;
   logic [DUTY_W-1:0]     rd_duty;
   logic                  start_ok;
   logic                  last_entry;
   logic                  last_pass;

   pattern_pwm_table #(
      ._PAT_WIDTH(_PAT_WIDTH),
      ._DEPTH    (_DEPTH)
   ) u_table (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (cfg_we && !seq_busy),
      .wr_addr(cfg_addr),
      .wr_pat (cfg_pat),
      .wr_duty(cfg_duty),
      .rd_addr(idx),
      .rd_pat (rd_pat),
      .rd_duty(rd_duty)
   );

   assign start_ok   = start && !stop && (seq_len != '0) &&
                       (seq_len <= (_ADDR_W+1)'(_DEPTH));
   assign last_entry = ({1'b0, idx} == len_q - (_ADDR_W+1)'(1));
   assign last_pass  = (rep_q != '0) && (pass == rep_q - _REP_W'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         pass      <= '0;
         len_q     <= '0;
         rep_q     <= '0;
         stop_flag <= 1'b0;
         pwm_en    <= 1'b0;
         duty_num  <= '0;
         PAT       <= '0;
         seq_busy  <= 1'b0;
         cur_idx   <= '0;
         done      <= 1'b0;
      end else begin
         pwm_en <= 1'b0;
         done   <= 1'b0;
         case (state)
            IDLE: begin
               stop_flag <= 1'b0;
               if (start_ok) begin
                  len_q    <= seq_len;
                  rep_q    <= rep_num;
                  idx      <= '0;
                  pass     <= '0;
                  seq_busy <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               // Nothing is outstanding here, so a stop can leave immediately.
               if (stop || stop_flag) begin
                  stop_flag <= 1'b0;
                  seq_busy  <= 1'b0;
                  state     <= IDLE;
               end else if (!pwm_busy) begin
                  pwm_en   <= 1'b1;
                  PAT      <= rd_pat;
                  duty_num <= rd_duty;
                  cur_idx  <= idx;
                  state    <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (stop) stop_flag <= 1'b1;
               // valid during our own pwm_en cycle belongs to an earlier job
               if (pwm_valid && !pwm_en) begin
                  if (stop || stop_flag) begin
                     stop_flag <= 1'b0;
                     seq_busy  <= 1'b0;
                     state     <= IDLE;
                  end else if (last_entry && last_pass) begin
                     seq_busy <= 1'b0;
                     done     <= 1'b1;
                     state    <= IDLE;
                  end else if (last_entry) begin
                     idx <= '0;
                     if (pass != '1) pass <= pass + _REP_W'(1);
                     state <= ISSUE;
                  end else begin
                     idx   <= idx + _ADDR_W'(1);
                     state <= ISSUE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_pwm_seq.sv
// Randomized bench for pattern_pwm_seq with a behavioural pattern_pwm and an issue-order model.
module tb_pattern_pwm_seq;
   import pattern_pwm_pkg::*;

   localparam int PW    = 16;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int RW    = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_we;
   logic [AW-1:0] cfg_addr;
   logic [PW-1:0] cfg_pat;
   logic [7:0]    cfg_duty;
   logic [AW:0]   seq_len;
   logic [RW-1:0] rep_num;
   logic          start, stop, pwm_busy, pwm_valid;
   logic          pwm_en, seq_busy, done;
   logic [7:0]    duty_num;
   logic [PW-1:0] PAT;
   logic [AW-1:0] cur_idx;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [PW-1:0] m_pat  [DEPTH];
   logic [7:0]    m_duty [DEPTH];

   always #5 clk = ~clk;

   pattern_pwm_seq #(._PAT_WIDTH(PW), ._DEPTH(DEPTH), ._REP_W(RW)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_pat(cfg_pat), .cfg_duty(cfg_duty), .seq_len(seq_len), .rep_num(rep_num),
      .start(start), .stop(stop), .pwm_busy(pwm_busy), .pwm_valid(pwm_valid),
      .pwm_en(pwm_en), .duty_num(duty_num), .PAT(PAT), .seq_busy(seq_busy),
      .cur_idx(cur_idx), .done(done)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic cfg_write(input int a, input logic [PW-1:0] p, input logic [7:0] d);
      cfg_we   = 1'b1;
      cfg_addr = a[AW-1:0];
      cfg_pat  = p;
      cfg_duty = d;
      tick();
      cfg_we   = 1'b0;
      m_pat[a]  = p;
      m_duty[a] = d;
   endtask

   task automatic check_quiet(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check_eq({tag, "_pwm_en"}, pwm_en, 1'b0);
         check_eq({tag, "_seq_busy"}, seq_busy, 1'b0);
         check_eq({tag, "_done"}, done, 1'b0);
      end
   endtask

   // Plays one run against a behavioural pattern_pwm. Expected issues are entry (k mod len)
   // for k = 0..total-1; each issue is due one edge after the trigger once pwm_busy is low.
   task automatic run(input int len, input int rep, input int stop_at, input int lat_max,
                      input int hold_max, input int start_hold, input int wr_during,
                      input int rand_start, input int trail);
      int total, issues, run_cnt, hold, armed, e_idx;
      bit pending, exp_busy, exp_done, ending, finished, just_issued, exp_en, natural;
      total    = (stop_at != 0) ? stop_at : len * rep;
      natural  = (stop_at == 0);
      issues   = 0;
      run_cnt  = 0;
      ending   = 1'b0;
      finished = 1'b0;
      exp_done = 1'b0;
      seq_len  = len[AW:0];
      rep_num  = rep[RW-1:0];
      start    = 1'b1;
      pwm_busy = 1'b0;
      pending  = 1'b1;
      armed    = cyc + 1;
      hold     = start_hold;
      exp_busy = 1'b1;
      tick();
      for (int b = 0; b < 3000 && !finished; b++) begin
         exp_en = pending && (cyc - 1 >= armed) && !pwm_busy;
         check_eq("pwm_en", pwm_en, exp_en);
         check_eq("seq_busy", seq_busy, exp_busy);
         check_eq("done", done, exp_done);
         exp_done    = 1'b0;
         just_issued = 1'b0;
         start = 1'b0; stop = 1'b0; pwm_valid = 1'b0; cfg_we = 1'b0;
         if (pwm_en && exp_en) begin
            e_idx = issues % len;
            check_eq("cur_idx", cur_idx, e_idx);
            check_eq("PAT", PAT, m_pat[e_idx]);
            check_eq("duty_num", duty_num, m_duty[e_idx]);
            issues++;
            pending     = 1'b0;
            just_issued = 1'b1;
            run_cnt     = $urandom_range(1, lat_max);
            if (stop_at != 0 && issues == stop_at) stop = 1'b1;
            if (wr_during != 0 && issues == 1) begin
               cfg_we = 1'b1; cfg_addr = '0; cfg_pat = 16'h1234; cfg_duty = 8'h77;
            end
         end
         if (ending) begin
            finished = 1'b1;
            pwm_busy = 1'b0;
         end else if (just_issued) begin
            pwm_busy = 1'b1;
         end else if (run_cnt > 0) begin
            run_cnt--;
            if (run_cnt == 0) begin
               pwm_valid = 1'b1;
               pwm_busy  = 1'b0;
               if (issues == total) begin
                  exp_busy = 1'b0;
                  exp_done = natural;
                  ending   = 1'b1;
               end else begin
                  pending = 1'b1;
                  armed   = cyc + 1;
                  hold    = $urandom_range(0, hold_max);
               end
            end else begin
               pwm_busy = 1'b1;
            end
         end else if (hold > 0) begin
            pwm_busy = 1'b1;
            hold--;
         end else begin
            pwm_busy = 1'b0;
         end
         if (rand_start != 0 && !ending && $urandom_range(0, 5) == 0) start = 1'b1;
         tick();
      end
      start = 1'b0; stop = 1'b0; pwm_valid = 1'b0; cfg_we = 1'b0; pwm_busy = 1'b0;
      if (!finished) check_eq("run_timeout", 0, 1);
      check_eq("issue_count", issues, total);
      check_quiet("after_run", trail);
   endtask

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_pat = '0; cfg_duty = '0;
      seq_len = '0; rep_num = '0; start = 1'b0; stop = 1'b0;
      pwm_busy = 1'b0; pwm_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin m_pat[i] = '0; m_duty[i] = '0; end

      // reset state
      tick(); tick();
      check_eq("rst_pwm_en", pwm_en, 1'b0);
      check_eq("rst_seq_busy", seq_busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_cur_idx", cur_idx, 0);
      check_eq("rst_PAT", PAT, 0);
      check_eq("rst_duty", duty_num, 0);
      rst_n = 1'b1;
      check_quiet("rst_release", 3);

      // basic pass, with a write attempt during the run
      cfg_write(0, 16'hAAAA, 8'd0);
      cfg_write(1, 16'h0000, 8'd0);
      cfg_write(2, 16'hFFFF, 8'd2);
      run(3, 1, 0, 3, 0, 0, 1, 0, 3);
      // wrap and repeat; entry0 must still be AAAA
      run(3, 2, 0, 4, 2, 0, 0, 1, 3);
      // infinite run stopped while entry 1 of the second pass runs
      run(3, 0, 5, 3, 1, 0, 0, 0, 100);
      // backpressure after start
      run(2, 1, 0, 2, 0, 20, 0, 0, 3);

      // illegal starts and stop-beats-start
      seq_len = '0; rep_num = 8'd1; start = 1'b1;
      tick(); start = 1'b0;
      check_quiet("len0", 2);
      seq_len = 4'd9; start = 1'b1;
      tick(); start = 1'b0;
      check_quiet("len9", 2);
      seq_len = 4'd3; start = 1'b1; stop = 1'b1;
      tick(); start = 1'b0; stop = 1'b0;
      check_quiet("start_stop", 2);

      // stop while still waiting to issue
      pwm_busy = 1'b1; seq_len = 4'd3; rep_num = 8'd1; start = 1'b1;
      tick(); start = 1'b0;
      check_eq("issue_busy", seq_busy, 1'b1);
      stop = 1'b1;
      tick(); stop = 1'b0; pwm_busy = 1'b0;
      check_eq("issue_stop_busy", seq_busy, 1'b0);
      check_eq("issue_stop_en", pwm_en, 1'b0);
      check_quiet("issue_stop", 5);

      // randomized table and runs
      for (int i = 0; i < DEPTH; i++) cfg_write(i, 16'($urandom), 8'($urandom));
      for (int r = 0; r < 6; r++)
         run($urandom_range(1, DEPTH), $urandom_range(1, 3), 0,
             $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 3), 0, 1, 2);

      // reset while waiting for completion
      cfg_write(0, 16'hC3C3, 8'd5);
      seq_len = 4'd2; rep_num = 8'd1; start = 1'b1;
      tick(); start = 1'b0;
      for (int w = 0; w < 10 && !pwm_en; w++) tick();
      check_eq("wd_issue", pwm_en, 1'b1);
      pwm_busy = 1'b1; rst_n = 1'b0;
      tick();
      check_eq("wd_rst_pwm_en", pwm_en, 1'b0);
      check_eq("wd_rst_seq_busy", seq_busy, 1'b0);
      check_eq("wd_rst_done", done, 1'b0);
      check_eq("wd_rst_cur_idx", cur_idx, 0);
      check_eq("wd_rst_PAT", PAT, 0);
      check_eq("wd_rst_duty", duty_num, 0);
      rst_n = 1'b1; pwm_busy = 1'b0;
      check_quiet("wd_release", 3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
